// File: rtl/sap1_muldiv_unit_pkg.sv
// Shared SAP-1 constants used by the controller and the multiply/divide unit:
// opcodes, control-word bit positions and the muldiv FSM encodings.
package sap1_muldiv_unit_pkg;

    localparam logic [3:0] OP_MUL            = 4'b0011;
    localparam logic [3:0] OP_DIV            = 4'b0100;
    localparam int         SIG_MULTIPLIER_EN = 12;
    localparam int         SIG_DIVIDER_EN    = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } muldiv_state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } muldiv_mode_e;

endpackage

// File: rtl/sap1_muldiv_unit_if.sv
// Controller <-> multiply/divide unit bus: start strobes, operands, status and results.
interface sap1_muldiv_unit_if #(parameter int WIDTH = 8);

    logic             mul_en;
    logic             div_en;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             ovf;
    logic             dbz;

    modport master (
        output mul_en, div_en, a_in, b_in,
        input  busy, done, result, result_hi, ovf, dbz
    );

    modport slave (
        input  mul_en, div_en, a_in, b_in,
        output busy, done, result, result_hi, ovf, dbz
    );

endinterface

// File: rtl/sap1_muldiv_step.sv
// One iteration of the unit: a shift-add multiply step or a restoring divide step.
// The accumulator is {hi, lo}; lo holds the multiplier (MUL) or the dividend/quotient (DIV).
module sap1_muldiv_step
    import sap1_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  muldiv_mode_e       mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;
    logic           ge_s;

    // Multiply: add multiplicand to the high half when the current multiplier bit is set.
    assign sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, operand} & {(WIDTH+1){acc[0]}});
    // Divide: bring the next dividend bit into the partial remainder and trial-subtract.
    assign shifted_s = acc[2*WIDTH-1:WIDTH-1];
    assign diff_s    = shifted_s - {1'b0, operand};
    assign ge_s      = ~diff_s[WIDTH];

    // Select the step result for the active mode.
    always_comb begin
        acc_next = acc;
        case (mode)
            MODE_MUL: acc_next = {sum_s, acc[WIDTH-1:1]};
            MODE_DIV: begin
                if (ge_s) begin
                    acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                end else begin
                    acc_next = {shifted_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                end
            end
            default: acc_next = acc;
        endcase
    end

endmodule

// File: rtl/sap1_muldiv_unit.sv
// Iterative unsigned multiply/divide unit answering the controller's MUL/DIV strobes.
// FSM, iteration counter and operand/accumulator registers; outputs update once per FIN.
module sap1_muldiv_unit
    import sap1_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    sap1_muldiv_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_e      state_r, state_next_s;
    muldiv_mode_e       mode_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   op_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_step_s;
    logic               last_iter_s;
    logic               op_zero_s;
    logic               busy_r, done_r, ovf_r, dbz_r;
    logic [WIDTH-1:0]   result_r, result_hi_r;

    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
    assign op_zero_s   = (op_r == {WIDTH{1'b0}});

    sap1_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (mode_r),
        .acc      (acc_r),
        .operand  (op_r),
        .acc_next (acc_step_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; multiply wins when both strobes arrive together.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.mul_en) begin
                    state_next_s = ST_MUL;
                end else if (bus.div_en) begin
                    state_next_s = ST_DIV;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_iter_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (op_zero_s || last_iter_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_DIV;
                end
            end
            ST_FIN:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand capture and iteration datapath; the divisor (or multiplicand) lives in op_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= MODE_MUL;
            cnt_r  <= {CNT_W{1'b0}};
            op_r   <= {WIDTH{1'b0}};
            acc_r  <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.mul_en) begin
                        mode_r <= MODE_MUL;
                        op_r   <= bus.a_in;
                        acc_r  <= {{WIDTH{1'b0}}, bus.b_in};
                        cnt_r  <= {CNT_W{1'b0}};
                    end else if (bus.div_en) begin
                        mode_r <= MODE_DIV;
                        op_r   <= bus.b_in;
                        acc_r  <= {{WIDTH{1'b0}}, bus.a_in};
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ST_MUL: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                ST_DIV: begin
                    if (op_zero_s) begin
                        // Divide by zero: remainder = dividend, quotient = all ones.
                        acc_r <= {acc_r[WIDTH-1:0], {WIDTH{1'b1}}};
                    end else begin
                        acc_r <= acc_step_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; results and flags change only when leaving FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_r == ST_FIN);
            if (state_r == ST_FIN) begin
                result_r    <= acc_r[WIDTH-1:0];
                result_hi_r <= acc_r[2*WIDTH-1:WIDTH];
                ovf_r       <= (mode_r == MODE_MUL) && (acc_r[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                dbz_r       <= (mode_r == MODE_DIV) && op_zero_s;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.ovf       = ovf_r;
    assign bus.dbz       = dbz_r;
    assign bus.result    = result_r;
    assign bus.result_hi = result_hi_r;

endmodule

// File: tb/tb_sap1_muldiv_unit.sv
// Scoreboard bench for sap1_muldiv_unit (WIDTH=8): stimulus queues expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_sap1_muldiv_unit;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   done_seen;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic       ovf;
        logic       dbz;
        int         lat;
        int         start;
    } exp_t;

    exp_t exp_q[$];

    sap1_muldiv_unit_if #(.WIDTH(8)) bus ();

    sap1_muldiv_unit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result",    bus.result,    e.res);
                chk("result_hi", bus.result_hi, e.hi);
                chk("ovf",       bus.ovf,       e.ovf);
                chk("dbz",       bus.dbz,       e.dbz);
                chk("latency",   cyc - e.start, e.lat);
            end
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [7:0] a, input logic [7:0] b,
                            input bit push, input logic [7:0] er, input logic [7:0] eh,
                            input logic eo, input logic ed, input int lat);
        exp_t e;
        @(posedge clk); #1;
        bus.mul_en = m;
        bus.div_en = d;
        bus.a_in   = a;
        bus.b_in   = b;
        if (push) begin
            e.res = er; e.hi = eh; e.ovf = eo; e.dbz = ed; e.lat = lat; e.start = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.mul_en = 1'b0;
        bus.div_en = 1'b0;
        bus.a_in   = 8'hA5;
        bus.b_in   = 8'h5A;
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL done_timeout: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        n_cmp = 0; n_err = 0; done_seen = 0; cyc = 0;
        rst = 1'b1;
        bus.mul_en = 1'b0; bus.div_en = 1'b0; bus.a_in = 8'h00; bus.b_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_result_hi", bus.result_hi, 0);
        chk("rst_flags", {bus.ovf, bus.dbz}, 0);
        rst = 1'b0;

        // 1. 13*11
        chk("idle_busy", bus.busy, 0);
        start_op(1'b1, 1'b0, 8'd13, 8'd11, 1'b1, 8'h8F, 8'h00, 1'b0, 1'b0, 9);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result", bus.result, 8'h8F);

        // 2. 200*3 overflows into the high byte; old result holds while busy
        start_op(1'b1, 1'b0, 8'd200, 8'd3, 1'b1, 8'h58, 8'h02, 1'b1, 1'b0, 9);
        chk("hold_during_busy", bus.result, 8'h8F);
        wait_done();

        // 3. 100/7
        start_op(1'b0, 1'b1, 8'd100, 8'd7, 1'b1, 8'h0E, 8'h02, 1'b0, 1'b0, 9);
        wait_done();

        // 4. divide by zero, then a multiply clears dbz
        start_op(1'b0, 1'b1, 8'd5, 8'd0, 1'b1, 8'hFF, 8'h05, 1'b0, 1'b1, 2);
        wait_done();
        chk("dbz_held", bus.dbz, 1);
        start_op(1'b1, 1'b0, 8'd6, 8'd7, 1'b1, 8'h2A, 8'h00, 1'b0, 1'b0, 9);
        wait_done();

        // 5. both strobes -> multiply; a div_en pulse mid-operation is ignored
        d0 = done_seen;
        start_op(1'b1, 1'b1, 8'd6, 8'd3, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0, 9);
        repeat (2) @(posedge clk);
        #1;
        bus.div_en = 1'b1; bus.a_in = 8'd50; bus.b_in = 8'd5;
        @(posedge clk); #1;
        bus.div_en = 1'b0;
        wait_done();
        repeat (12) @(posedge clk);
        #1;
        chk("single_done", done_seen - d0, 1);
        chk("idle_after_ignored", bus.busy, 0);

        // 6. reset in the middle of a divide
        start_op(1'b0, 1'b1, 8'd100, 8'd7, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_result_hi", bus.result_hi, 0);
        chk("midrst_flags", {bus.ovf, bus.dbz}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_result", bus.result, 0);
        start_op(1'b1, 1'b0, 8'd9, 8'd9, 1'b1, 8'h51, 8'h00, 1'b0, 1'b0, 9);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
